// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the initiator state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PIPE,
    ST_DATA,
    ST_ERR2
  } ahb_mst_state_t;

  // True when an incrementing word address has just stepped onto a 1KB boundary.
  function automatic logic on_1kb_boundary(input logic [31:0] addr);
    return addr[9:0] == 10'd0;
  endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns word read/write commands of 1..MAX_LEN beats into
// pipelined AHB-Lite transfers with wait states, BUSY, 1KB splitting and ERROR abort.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wd_valid,
  output logic             wd_ready,
  input  logic [31:0]      wd_data,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             rsp_last,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  output ahb_mst_state_t   dbg_state_o
);

  // Handshakes: cmd and wd transfer on the cycle where valid && ready are both high.
  // An offered write beat (wd_valid) must stay asserted until it is taken.
  ahb_mst_state_t   state_q;
  logic [31:0]      haddr_q, hwdata_q, rsp_rdata_q;
  logic [1:0]       tr_q;
  logic             hwrite_q, committed_q;
  logic [2:0]       hburst_q;
  logic [LEN_W-1:0] len_q, issued_q, done_q;
  logic             rsp_valid_q, rsp_err_q, rsp_last_q;

  logic             data_pend, addr_stage, tr_active, stall_wd;
  logic             err_now, addr_done, data_done, issue_last, done_last;
  logic [1:0]       htrans_c;
  logic [31:0]      next_addr;
  logic [LEN_W-1:0] cmd_len_eff;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr[1:0];

  always_comb begin
    data_pend   = (state_q == ST_PIPE) || (state_q == ST_DATA);
    addr_stage  = (state_q == ST_ADDR) || (state_q == ST_PIPE);
    tr_active   = addr_stage && ((tr_q == HTRANS_NONSEQ) || (tr_q == HTRANS_SEQ));
    // A write beat with no data yet shows as BUSY (mid-burst) or IDLE (burst start),
    // unless the transfer was already exposed during a wait state.
    stall_wd    = tr_active && hwrite_q && !wd_valid && !committed_q;
    htrans_c    = tr_q;
    if (stall_wd) htrans_c = (tr_q == HTRANS_SEQ) ? HTRANS_BUSY : HTRANS_IDLE;
    err_now     = data_pend && (HRESP == HRESP_ERROR);
    addr_done   = tr_active && !stall_wd && HREADY && !err_now;
    data_done   = data_pend && HREADY && !err_now;
    issue_last  = (issued_q + 1'b1) == len_q;
    done_last   = (done_q + 1'b1) == len_q;
    next_addr   = haddr_q + 32'd4;
    cmd_len_eff = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      haddr_q     <= '0;
      tr_q        <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hburst_q    <= HBURST_SINGLE;
      hwdata_q    <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      done_q      <= '0;
      committed_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            haddr_q     <= {cmd_addr[31:2], 2'b00};
            hwrite_q    <= cmd_write;
            len_q       <= cmd_len_eff;
            hburst_q    <= (cmd_len_eff == LEN_W'(1)) ? HBURST_SINGLE : HBURST_INCR;
            tr_q        <= HTRANS_NONSEQ;
            issued_q    <= '0;
            done_q      <= '0;
            committed_q <= 1'b0;
            state_q     <= ST_ADDR;
          end
        end
        ST_ERR2: begin
          if (HREADY) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_last_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        ST_ADDR, ST_PIPE, ST_DATA: begin
          if (err_now) begin
            // Remaining beats are dropped; the bus sees IDLE from the second error cycle.
            tr_q        <= HTRANS_IDLE;
            committed_q <= 1'b0;
            if (HREADY) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_last_q  <= 1'b1;
              state_q     <= ST_IDLE;
            end else begin
              state_q <= ST_ERR2;
            end
          end else begin
            if (data_done) begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= hwrite_q ? 32'd0 : HRDATA;
              rsp_last_q  <= done_last;
              done_q      <= done_q + 1'b1;
            end
            if (addr_done) begin
              issued_q    <= issued_q + 1'b1;
              committed_q <= 1'b0;
              if (hwrite_q) hwdata_q <= wd_data;
              if (issue_last) begin
                tr_q <= HTRANS_IDLE;
              end else begin
                haddr_q <= next_addr;
                tr_q    <= on_1kb_boundary(next_addr) ? HTRANS_NONSEQ : HTRANS_SEQ;
              end
            end else if (tr_active && !stall_wd && !HREADY) begin
              committed_q <= 1'b1;
            end
            if (data_done && done_last) state_q <= ST_IDLE;
            else if (addr_done)         state_q <= issue_last ? ST_DATA : ST_PIPE;
            else if (data_pend && !data_done) state_q <= state_q;
            else                        state_q <= ST_ADDR;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign wd_ready    = addr_done && hwrite_q;
  assign HADDR       = haddr_q;
  assign HTRANS      = htrans_c;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = HSIZE_WORD;
  assign HBURST      = hburst_q;
  assign HWDATA      = hwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_last    = rsp_last_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: the bench plays the AHB slave cycle by cycle.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic             HCLK = 1'b0;
  logic             HRESET;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             wd_valid, wd_ready;
  logic [31:0]      wd_data;
  logic             rsp_valid, rsp_err, rsp_last;
  logic [31:0]      rsp_rdata;
  logic [31:0]      HADDR, HWDATA, HRDATA;
  logic [1:0]       HTRANS;
  logic             HWRITE, HREADY, HRESP;
  logic [2:0]       HSIZE, HBURST;
  ahb_mst_state_t   dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] t4_addr [8] = '{32'h3F8, 32'h3FC, 32'h400, 32'h404,
                               32'h408, 32'h40C, 32'h410, 32'h414};
  logic [1:0]  t4_tr   [8] = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_NONSEQ, HTRANS_SEQ,
                               HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ};

  ahb_lite_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_last(rsp_last),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .dbg_state_o(dbg_state)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    tick(); tick();
    #2;
    chk("rst_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'h0);
    chk("rst_hburst", 32'(HBURST), 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_hsize", 32'(HSIZE), 32'h2);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_wd_ready", 32'(wd_ready), 32'h0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_last}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    HRESET = 1'b0;
    tick();

    // single read at 0x100, no waits: rsp three cycles after accept
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100; cmd_len = 5'd1; #2;
    chk("t1_cmd_ready", 32'(cmd_ready), 32'h1); tick();
    cmd_valid = 1'b0; #2;
    chk("t1_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    chk("t1_haddr", HADDR, 32'h100);
    chk("t1_hburst", 32'(HBURST), 32'(HBURST_SINGLE));
    chk("t1_hwrite", 32'(HWRITE), 32'h0);
    tick();
    HRDATA = 32'hDEADBEEF; #2;
    chk("t1_t2_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("t1_t2_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    HRDATA = 32'h0; #2;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t1_rsp_last", 32'(rsp_last), 32'h1);
    chk("t1_rsp_err", 32'(rsp_err), 32'h0);
    tick();
    #2; chk("t1_rsp_pulse", 32'(rsp_valid), 32'h0);
    tick();

    // 4-beat write at 0x200, beat 2 address held through two wait states
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h200; cmd_len = 5'd4;
    wd_valid = 1'b1; wd_data = 32'hA000_0000; #2;
    chk("t2_cmd_ready", 32'(cmd_ready), 32'h1); tick();
    cmd_valid = 1'b0; #2;
    chk("t2_c1_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    chk("t2_c1_haddr", HADDR, 32'h200);
    chk("t2_c1_hburst", 32'(HBURST), 32'(HBURST_INCR));
    chk("t2_c1_hwrite", 32'(HWRITE), 32'h1);
    chk("t2_c1_wd_ready", 32'(wd_ready), 32'h1);
    tick();
    wd_data = 32'hA000_0001; HREADY = 1'b0; #2;
    chk("t2_c2_htrans", 32'(HTRANS), 32'(HTRANS_SEQ));
    chk("t2_c2_haddr", HADDR, 32'h204);
    chk("t2_c2_wd_ready", 32'(wd_ready), 32'h0);
    chk("t2_c2_hwdata", HWDATA, 32'hA000_0000);
    tick();
    #2;
    chk("t2_c3_htrans", 32'(HTRANS), 32'(HTRANS_SEQ));
    chk("t2_c3_haddr", HADDR, 32'h204);
    chk("t2_c3_hburst", 32'(HBURST), 32'(HBURST_INCR));
    chk("t2_c3_hwdata", HWDATA, 32'hA000_0000);
    chk("t2_c3_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    HREADY = 1'b1; #2;
    chk("t2_c4_wd_ready", 32'(wd_ready), 32'h1);
    chk("t2_c4_haddr", HADDR, 32'h204);
    tick();
    wd_data = 32'hA000_0002; #2;
    chk("t2_c5_rsp", {rsp_valid, rsp_last}, 32'h2);
    chk("t2_c5_rdata", rsp_rdata, 32'h0);
    chk("t2_c5_haddr", HADDR, 32'h208);
    chk("t2_c5_htrans", 32'(HTRANS), 32'(HTRANS_SEQ));
    chk("t2_c5_hwdata", HWDATA, 32'hA000_0001);
    tick();
    wd_data = 32'hA000_0003; #2;
    chk("t2_c6_haddr", HADDR, 32'h20C);
    chk("t2_c6_htrans", 32'(HTRANS), 32'(HTRANS_SEQ));
    chk("t2_c6_hwdata", HWDATA, 32'hA000_0002);
    chk("t2_c6_rsp", {rsp_valid, rsp_last}, 32'h2);
    tick();
    wd_valid = 1'b0; #2;
    chk("t2_c7_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("t2_c7_hwdata", HWDATA, 32'hA000_0003);
    chk("t2_c7_rsp", {rsp_valid, rsp_last}, 32'h2);
    chk("t2_c7_state", 32'(dbg_state), 32'(ST_DATA));
    tick();
    #2;
    chk("t2_c8_rsp", {rsp_valid, rsp_last}, 32'h3);
    chk("t2_c8_cmd_ready", 32'(cmd_ready), 32'h1);
    tick();

    // 4-beat write at 0x280, write data withheld three cycles before beat 3
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h280; cmd_len = 5'd4;
    wd_valid = 1'b1; wd_data = 32'hB000_0000; #2; tick();
    cmd_valid = 1'b0; #2;
    chk("t3_c1_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    chk("t3_c1_wd_ready", 32'(wd_ready), 32'h1);
    tick();
    wd_data = 32'hB000_0001; #2;
    chk("t3_c2_htrans", 32'(HTRANS), 32'(HTRANS_SEQ));
    chk("t3_c2_haddr", HADDR, 32'h284);
    tick();
    for (int k = 0; k < 3; k++) begin
      wd_valid = 1'b0; #2;
      chk($sformatf("t3_busy%0d_htrans", k), 32'(HTRANS), 32'(HTRANS_BUSY));
      chk($sformatf("t3_busy%0d_haddr", k), HADDR, 32'h288);
      chk($sformatf("t3_busy%0d_wd_ready", k), 32'(wd_ready), 32'h0);
      chk($sformatf("t3_busy%0d_rsp", k), 32'(rsp_valid), (k < 2) ? 32'h1 : 32'h0);
      tick();
    end
    wd_valid = 1'b1; wd_data = 32'hB000_0002; #2;
    chk("t3_c6_htrans", 32'(HTRANS), 32'(HTRANS_SEQ));
    chk("t3_c6_haddr", HADDR, 32'h288);
    chk("t3_c6_wd_ready", 32'(wd_ready), 32'h1);
    chk("t3_c6_hwdata", HWDATA, 32'hB000_0001);
    tick();
    wd_data = 32'hB000_0003; #2;
    chk("t3_c7_haddr", HADDR, 32'h28C);
    chk("t3_c7_hwdata", HWDATA, 32'hB000_0002);
    tick();
    wd_valid = 1'b0; #2;
    chk("t3_c8_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("t3_c8_hwdata", HWDATA, 32'hB000_0003);
    chk("t3_c8_rsp", {rsp_valid, rsp_last}, 32'h2);
    tick();
    #2;
    chk("t3_c9_rsp", {rsp_valid, rsp_last}, 32'h3);
    tick();

    // 8-beat read from 0x3F8: burst restarts with NONSEQ at 0x400
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3F8; cmd_len = 5'd8; #2; tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      HRDATA = 32'h5000_0000 + 32'(c); #2;
      if (c <= 8) begin
        chk($sformatf("t4_c%0d_haddr", c), HADDR, t4_addr[c-1]);
        chk($sformatf("t4_c%0d_htrans", c), 32'(HTRANS), 32'(t4_tr[c-1]));
      end else begin
        chk($sformatf("t4_c%0d_htrans", c), 32'(HTRANS), 32'(HTRANS_IDLE));
      end
      if (c >= 3) begin
        chk($sformatf("t4_c%0d_rsp", c), {rsp_valid, rsp_last}, (c == 10) ? 32'h3 : 32'h2);
        chk($sformatf("t4_c%0d_rdata", c), rsp_rdata, 32'h5000_0000 + 32'(c - 1));
      end else begin
        chk($sformatf("t4_c%0d_rsp", c), 32'(rsp_valid), 32'h0);
      end
      tick();
    end
    #2; chk("t4_end_rsp", 32'(rsp_valid), 32'h0);
    chk("t4_end_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();

    // 8-beat read from 0x042 (low bits ignored), ERROR on beat 3
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h042; cmd_len = 5'd8; #2; tick();
    cmd_valid = 1'b0; #2;
    chk("t5_c1_haddr", HADDR, 32'h040);
    chk("t5_c1_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    tick();
    HRDATA = 32'h0A0A_0001; #2;
    chk("t5_c2_haddr", HADDR, 32'h044);
    tick();
    HRDATA = 32'h0A0A_0002; #2;
    chk("t5_c3_rsp", {rsp_valid, rsp_err, rsp_last}, 32'h4);
    chk("t5_c3_rdata", rsp_rdata, 32'h0A0A_0001);
    chk("t5_c3_haddr", HADDR, 32'h048);
    tick();
    HRESP = 1'b1; HREADY = 1'b0; #2;
    chk("t5_c4_rsp", {rsp_valid, rsp_err, rsp_last}, 32'h4);
    chk("t5_c4_rdata", rsp_rdata, 32'h0A0A_0002);
    tick();
    HREADY = 1'b1; #2;
    chk("t5_err2_state", 32'(dbg_state), 32'(ST_ERR2));
    chk("t5_err2_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("t5_err2_rsp", 32'(rsp_valid), 32'h0);
    tick();
    HRESP = 1'b0; #2;
    chk("t5_c6_rsp", {rsp_valid, rsp_err, rsp_last}, 32'h7);
    chk("t5_c6_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("t5_c6_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("t5_c6_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    #2;
    chk("t5_c7_rsp", 32'(rsp_valid), 32'h0);
    chk("t5_c7_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    tick();

    // reset in the middle of a 16-beat write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h500; cmd_len = 5'd16;
    wd_valid = 1'b1; wd_data = 32'h0000_0077; #2; tick();
    cmd_valid = 1'b0; tick(); tick();
    #2;
    chk("t6_pre_haddr", HADDR, 32'h508);
    chk("t6_pre_htrans", 32'(HTRANS), 32'(HTRANS_SEQ));
    HRESET = 1'b1; tick();
    HRESET = 1'b0; #2;
    chk("t6_htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("t6_haddr", HADDR, 32'h0);
    chk("t6_hwrite", 32'(HWRITE), 32'h0);
    chk("t6_hburst", 32'(HBURST), 32'h0);
    chk("t6_hwdata", HWDATA, 32'h0);
    chk("t6_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("t6_wd_ready", 32'(wd_ready), 32'h0);
    chk("t6_rsp", {rsp_valid, rsp_err, rsp_last}, 32'h0);
    chk("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    wd_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
